// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, width defaults and address checking for the instruction memory
package imem_pkg;

    typedef enum logic [2:0] {IDLE, WAIT, RD0, RD1, RESP} imem_state_e;

    localparam int unsigned IMEM_MEM_SIZE = 1048576;
    localparam int unsigned IMEM_LATENCY  = 1;
    localparam int unsigned IMEM_AW       = $clog2(IMEM_MEM_SIZE) - 2;
    localparam int unsigned IMEM_CW       = $clog2(IMEM_LATENCY + 1);

    // A request is serviceable when it lies inside the array and, with halfword
    // fetch enabled, is at least halfword aligned.
    function automatic logic imem_addr_ok(input logic [31:0] addr, input logic [32:0] size,
                                          input logic half_align);
        return ({1'b0, addr} < size) && !(half_align && addr[0]);
    endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: 1R1W synchronous word RAM, read returns the pre-write contents
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    // Write port and registered read port; non-blocking update gives read-before-write
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch: latency-programmable instruction fetch with halfword stitching and error reporting
module imem_fetch
    import imem_pkg::*;
#(
    parameter int unsigned MEM_SIZE   = IMEM_MEM_SIZE,
    parameter int unsigned LATENCY    = IMEM_LATENCY,
    parameter int unsigned HALF_ALIGN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata
);

    localparam int unsigned DEPTH    = MEM_SIZE / 4;
    localparam int unsigned AW       = $clog2(MEM_SIZE) - 2;
    localparam int unsigned CW       = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [32:0] SIZE     = 33'(MEM_SIZE);
    localparam logic HALF_EN         = (HALF_ALIGN != 0);

    imem_state_e   r_state, w_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [AW-1:0] r_w, w_raddr, w_in_w;
    logic          r_half, r_bad, r_err;
    logic [15:0]   r_lo;
    logic [31:0]   r_rdata, w_q;
    logic          w_accept, w_ok, w_in_half, w_re, w_prog_ok;

    assign w_accept  = (r_state == IDLE) && mem_valid && !mem_ready;
    assign w_ok      = imem_addr_ok(mem_addr, SIZE, HALF_EN);
    assign w_in_w    = mem_addr[AW+1:2];
    assign w_in_half = HALF_EN && mem_addr[1];
    assign w_prog_ok = {1'b0, prog_addr} < SIZE;

    assign mem_ready = (r_state == RESP);
    assign mem_rdata = r_rdata;
    assign mem_err   = r_err;

    imem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk    (clk),
        .i_we   (prog_we && w_prog_ok),
        .i_waddr(prog_addr[AW+1:2]),
        .i_wdata(prog_wdata),
        .i_re   (w_re),
        .i_raddr(w_raddr),
        .o_rdata(w_q)
    );

    // Next state, wait countdown and read issue; each read is issued on the edge
    // entering RD0/RD1 so the word is on the array output during that state
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_re       = 1'b0;
        w_raddr    = r_w;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_cnt_next = w_ok ? CNT_LOAD : '0;
                    w_next     = (!w_ok || CNT_LOAD != '0) ? WAIT : RD0;
                    w_re       = w_ok && CNT_LOAD == '0;
                    w_raddr    = w_in_w;
                end
            end
            WAIT: begin
                w_cnt_next = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
                w_next     = r_bad ? RESP : (r_cnt == CW'(1)) ? RD0 : WAIT;
                w_re       = !r_bad && r_cnt == CW'(1);
            end
            RD0: begin
                w_next  = r_half ? RD1 : RESP;
                w_re    = r_half;
                w_raddr = r_w + 1'b1;
            end
            RD1:     w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, request capture, low-half staging and response registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_w     <= '0;
            r_half  <= 1'b0;
            r_bad   <= 1'b0;
            r_lo    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_w    <= w_in_w;
                r_half <= w_in_half;
                r_bad  <= !w_ok;
            end
            if (r_state == RD0) r_lo <= w_q[31:16];
            if (w_next == RESP) begin
                r_err   <= r_bad;
                r_rdata <= r_bad ? '0 : r_half ? {w_q[15:0], r_lo} : w_q;
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch.sv
// tb_imem_fetch: directed checks of latency, halfword stitching, errors and reset
module tb_imem_fetch;
    import imem_pkg::*;

    logic              clk = 0;
    logic              reset = 1;
    logic [2:0]        valid = '0;
    logic [2:0][31:0]  addr = '0;
    logic [2:0]        ready, err;
    logic [2:0][31:0]  rdata;
    logic              prog_we = 0;
    logic [31:0]       prog_addr = '0, prog_wdata = '0;
    int                pass = 0, total = 0;

    always #5 clk = ~clk;

    imem_fetch #(.MEM_SIZE(4096), .LATENCY(1), .HALF_ALIGN(1)) u_d0 (
        .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_addr(addr[0]),
        .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_err(err[0]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_fetch #(.MEM_SIZE(4096), .LATENCY(1), .HALF_ALIGN(0)) u_d1 (
        .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_addr(addr[1]),
        .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_err(err[1]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    imem_fetch #(.MEM_SIZE(16), .LATENCY(4), .HALF_ALIGN(1)) u_d2 (
        .clk(clk), .reset(reset), .mem_valid(valid[2]), .mem_addr(addr[2]),
        .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_err(err[2]),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata));

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1; prog_addr = a; prog_wdata = d;
        @(negedge clk);
        prog_we = 0;
    endtask

    // Called just after a negedge; returns at the negedge where ready is seen
    task automatic fetch(input int s, input logic [31:0] a, output int cyc,
                         output logic [31:0] d, output logic e);
        valid[s] = 1; addr[s] = a; cyc = 0;
        do begin @(negedge clk); cyc++; end while (!ready[s] && cyc < 40);
        d = rdata[s]; e = err[s]; valid[s] = 0;
    endtask

    task automatic test_reset;
        @(negedge clk); @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            total++; if (ready[s] !== 1'b0) $display("FAIL reset_ready[%0d] got %b want 0", s, ready[s]); else pass++;
            total++; if (err[s] !== 1'b0) $display("FAIL reset_err[%0d] got %b want 0", s, err[s]); else pass++;
            total++; if (rdata[s] !== 32'h0) $display("FAIL reset_rdata[%0d] got %h want 0", s, rdata[s]); else pass++;
        end
        reset = 0;
        @(negedge clk);
        load(32'h0, 32'h11112222);
        load(32'h4, 32'h33334444);
        load(32'h8, 32'h55556666);
        load(32'hC, 32'h77778888);
        load(32'hFFC, 32'hABCD0123);
    endtask

    task automatic test_aligned;
        int c; logic [31:0] d; logic e;
        fetch(0, 32'h0, c, d, e);
        total++; if (c !== 2) $display("FAIL aligned_cycles got %0d want 2", c); else pass++;
        total++; if (d !== 32'h11112222) $display("FAIL aligned_data got %h want 11112222", d); else pass++;
        total++; if (e !== 1'b0) $display("FAIL aligned_err got %b want 0", e); else pass++;
        @(negedge clk);
        total++; if (ready[0] !== 1'b0) $display("FAIL aligned_single_pulse got %b want 0", ready[0]); else pass++;
        total++; if (rdata[0] !== 32'h11112222) $display("FAIL aligned_hold got %h want 11112222", rdata[0]); else pass++;
    endtask

    task automatic test_halfword;
        int c; logic [31:0] d; logic e;
        fetch(0, 32'h2, c, d, e);
        total++; if (c !== 3) $display("FAIL half_cycles got %0d want 3", c); else pass++;
        total++; if (d !== 32'h44441111) $display("FAIL half_data got %h want 44441111", d); else pass++;
        total++; if (e !== 1'b0) $display("FAIL half_err got %b want 0", e); else pass++;
        @(negedge clk);
        fetch(0, 32'hFFE, c, d, e);
        total++; if (c !== 3) $display("FAIL half_wrap_cycles got %0d want 3", c); else pass++;
        total++; if (d !== 32'h2222ABCD) $display("FAIL half_wrap_data got %h want 2222abcd", d); else pass++;
        @(negedge clk);
        fetch(0, 32'h1000, c, d, e);
        total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL range_err got err=%b data=%h want err=1 data=0", e, d); else pass++;
        @(negedge clk);
        fetch(1, 32'h2, c, d, e);
        total++; if (c !== 2) $display("FAIL word_mode_cycles got %0d want 2", c); else pass++;
        total++; if (d !== 32'h11112222) $display("FAIL word_mode_data got %h want 11112222", d); else pass++;
        @(negedge clk);
        fetch(1, 32'h1, c, d, e);
        total++; if (e !== 1'b0 || d !== 32'h11112222) $display("FAIL word_mode_odd got err=%b data=%h want err=0 data=11112222", e, d); else pass++;
        @(negedge clk);
    endtask

    task automatic test_latency4;
        int c; logic [31:0] d; logic e;
        fetch(2, 32'hC, c, d, e);
        total++; if (c !== 5) $display("FAIL lat4_aligned_cycles got %0d want 5", c); else pass++;
        total++; if (d !== 32'h77778888) $display("FAIL lat4_aligned_data got %h want 77778888", d); else pass++;
        @(negedge clk);
        fetch(2, 32'hE, c, d, e);
        total++; if (c !== 6) $display("FAIL lat4_wrap_cycles got %0d want 6", c); else pass++;
        total++; if (d !== 32'h22227777) $display("FAIL lat4_wrap_data got %h want 22227777", d); else pass++;
        @(negedge clk);
        fetch(2, 32'h10, c, d, e);
        total++; if (c !== 2) $display("FAIL lat4_err_cycles got %0d want 2", c); else pass++;
        total++; if (e !== 1'b1 || d !== 32'h0) $display("FAIL lat4_err got err=%b data=%h want err=1 data=0", e, d); else pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int c; logic [31:0] d; logic e;
        fetch(0, 32'h1, c, d, e);
        total++; if (c !== 2 || e !== 1'b1 || d !== 32'h0) $display("FAIL misalign_err got cyc=%0d err=%b data=%h want cyc=2 err=1 data=0", c, e, d); else pass++;
        fetch(0, 32'h4, c, d, e);
        total++; if (c !== 3) $display("FAIL b2b_cycles got %0d want 3", c); else pass++;
        total++; if (d !== 32'h33334444 || e !== 1'b0) $display("FAIL b2b_data got err=%b data=%h want err=0 data=33334444", e, d); else pass++;
        @(negedge clk);
        total++; if (ready[0] !== 1'b0) $display("FAIL b2b_single_pulse got %b want 0", ready[0]); else pass++;
    endtask

    task automatic test_write_during_wait;
        int c; logic [31:0] d; logic e;
        valid[2] = 1; addr[2] = 32'h0; c = 0;
        @(negedge clk); c++;
        prog_we = 1; prog_addr = 32'h0; prog_wdata = 32'hDEADBEEF;
        @(negedge clk); c++;
        prog_we = 0;
        while (!ready[2] && c < 40) begin @(negedge clk); c++; end
        valid[2] = 0;
        total++; if (c !== 5 || rdata[2] !== 32'hDEADBEEF) $display("FAIL wait_write got cyc=%0d data=%h want cyc=5 data=deadbeef", c, rdata[2]); else pass++;
        @(negedge clk);
        load(32'h0, 32'h11112222);
        valid[2] = 1; addr[2] = 32'h0; c = 0;
        repeat (3) begin @(negedge clk); c++; end
        prog_we = 1; prog_addr = 32'h0; prog_wdata = 32'hCAFEF00D;
        @(negedge clk); c++;
        prog_we = 0;
        while (!ready[2] && c < 40) begin @(negedge clk); c++; end
        valid[2] = 0;
        total++; if (c !== 5 || rdata[2] !== 32'h11112222) $display("FAIL same_edge_write got cyc=%0d data=%h want cyc=5 data=11112222", c, rdata[2]); else pass++;
        @(negedge clk);
        fetch(2, 32'h0, c, d, e);
        total++; if (d !== 32'hCAFEF00D) $display("FAIL same_edge_landed got %h want cafef00d", d); else pass++;
        @(negedge clk);
        load(32'h0, 32'h11112222);
    endtask

    task automatic test_reset_in_wait;
        int c; logic [31:0] d; logic e;
        valid[2] = 1; addr[2] = 32'h4;
        @(negedge clk); @(negedge clk);
        total++; if (u_d2.r_state !== WAIT) $display("FAIL pre_reset_state got %0d want WAIT", u_d2.r_state); else pass++;
        reset = 1; valid[2] = 0;
        #1;
        total++; if (ready[2] !== 1'b0 || err[2] !== 1'b0) $display("FAIL async_reset_flags got ready=%b err=%b want 0 0", ready[2], err[2]); else pass++;
        total++; if (rdata[2] !== 32'h0) $display("FAIL async_reset_rdata got %h want 0", rdata[2]); else pass++;
        total++; if (u_d2.r_state !== IDLE || u_d2.r_cnt !== 3'd0) $display("FAIL async_reset_state got state=%0d cnt=%0d want IDLE 0", u_d2.r_state, u_d2.r_cnt); else pass++;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        fetch(2, 32'h4, c, d, e);
        total++; if (c !== 5 || d !== 32'h33334444) $display("FAIL post_reset_fetch got cyc=%0d data=%h want cyc=5 data=33334444", c, d); else pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_halfword;
        test_latency4;
        test_back_to_back;
        test_write_during_wait;
        test_reset_in_wait;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
